fb_fill_engine: RTL and testbench
=================================

// Module: fb_fill_engine
// PURPOSE
//  Rectangle-fill engine sitting directly upstream of the framebuffer write port.
//  The CPU programs origin, size and colour through a small register bus and starts the operation.
//  The engine then streams one 32-bit word (two RGB565 pixels) per cycle into the framebuffer.
//  CPU framebuffer stores are merged through the same port and always take priority over the engine.
// PARAMETERS
//  ADDR_W   18   framebuffer word-address width (matches framebuffer write offset)
//  STRIDE   320  words per scanline (640 px / 2 px per word)
//  HEIGHT   480  scanlines
// PORTS
//  CLK          in   1       system clock (single clock domain)
//  RST_X        in   1       reset, asynchronous, active-low
//  i_cfg_we     in   1       register write strobe
//  i_cfg_addr   in   3       register index: 0 X0, 1 Y0, 2 W, 3 H, 4 COLOR, 5 CTRL
//  i_cfg_wdata  in   32      register write data
//  o_cfg_rdata  out  32      register read data (combinational, from i_cfg_addr)
//  i_cpu_we     in   1       CPU framebuffer store request
//  i_cpu_offset in   ADDR_W  CPU store word offset
//  i_cpu_wdata  in   32      CPU store data
//  o_fb_we      out  1       framebuffer write enable (registered)
//  o_fb_offset  out  ADDR_W  framebuffer word offset (registered)
//  o_fb_wdata   out  32      framebuffer write data (registered)
//  o_irq        out  1       done & irq_en (level)
// BEHAVIOUR
//  Registers:
//   - X0 and W are in words, 9 bits; Y0 and H are 9 bits; COLOR is 32 bits; unused bits read 0.
//   - CTRL write: bit0 start (pulse), bit1 writing 1 clears done, bit2 abort (pulse), bit3 irq_en.
//   - CTRL read: bit0 busy, bit1 done, bit3 irq_en.
//  Reset: all registers 0, state IDLE, o_fb_we/o_fb_offset/o_fb_wdata 0, o_irq 0.
//  FSM states:
//   - IDLE: a start write latches X0, Y0, W, H and COLOR into shadow copies -> SETUP; busy=1 from the next cycle.
//   - SETUP (1 cycle): clip w' = min(W, STRIDE-X0) and h' = min(H, HEIGHT-Y0).
//     Compute row base = Y0*STRIDE + X0 and zero the column/row counters.
//     If X0>=STRIDE, Y0>=HEIGHT, w'==0 or h'==0 -> DONE with no writes.
//   - RUN: issue one write per cycle at base+col, then col++.
//     At col==w'-1: col=0, base+=STRIDE, row++.
//     The last write (row==h'-1, col==w'-1) -> DONE.
//   - DONE (1 cycle): set done=1 (sticky), busy=0 -> IDLE.
//  Latency:
//   - Start written at edge N: first engine write presented on o_fb_* after edge N+2.
//   - Total engine writes = w'*h', contiguous when no CPU stalls; busy reads 0 after the DONE cycle.
//  Arbitration:
//   - i_cpu_we=1 in a cycle -> the CPU store is registered to o_fb_* (1-cycle latency).
//   - The engine holds its counters that cycle (stall, no write lost or duplicated).
//  Boundary conditions:
//   - Start while busy is ignored.
//   - Config writes while busy update the registers only; the active fill uses the shadow copies.
//   - Abort in any non-IDLE state -> IDLE next edge; done is not set; writes already issued stand.
//   - Abort and start in the same CTRL write: abort wins, and the engine returns to IDLE.
//   - Done-clear and DONE state in the same cycle: done ends at 1 (set wins).
//   - Reset mid-fill: immediate return to IDLE with o_fb_we=0.
//   - Offsets never exceed STRIDE*HEIGHT-1; all arithmetic is ADDR_W bits with no wrap by construction.
// TESTING
//  1. X0=2,Y0=3,W=4,H=2,COLOR=0xF800F800, start -> 8 writes: offsets 962..965 then 1282..1285, data 0xF800F800.
//     First write 2 edges after start; done=1.
//  2. W=0 or H=0, start -> zero o_fb_we pulses; done=1 three edges after start; busy never visible in RUN.
//  3. X0=318,W=10,Y0=479,H=5 -> clipped to 2 writes: offsets 153598, 153599; then done.
//  4. Fill W=4,H=1 with i_cpu_we pulsed on the 2nd engine cycle (offset 7, data 0x1234) ->
//     o_fb_* shows the CPU write; engine writes resume in order; 4 engine writes total, none duplicated.
//  5. Abort after 3 of 16 writes -> exactly 3 writes, busy=0, done=0.
//     A new start then works normally; irq_en=1 gives o_irq=1 at completion, and clearing done drops it.
//  6. RST_X asserted mid-RUN -> o_fb_we=0 asynchronously; all registers read 0 after release.

Source files
------------

// File: rtl/fb_fill_engine_if.sv
// Register, CPU-store and framebuffer-write signals of the rectangle-fill engine.
// The master side (CPU/testbench) drives the requests and the slave side (engine) drives the responses.
interface fb_fill_engine_if #(
  parameter int ADDR_W = 18
);
  logic              i_cfg_we;
  logic [2:0]        i_cfg_addr;
  logic [31:0]       i_cfg_wdata;
  logic [31:0]       o_cfg_rdata;
  logic              i_cpu_we;
  logic [ADDR_W-1:0] i_cpu_offset;
  logic [31:0]       i_cpu_wdata;
  logic              o_fb_we;
  logic [ADDR_W-1:0] o_fb_offset;
  logic [31:0]       o_fb_wdata;
  logic              o_irq;

  modport master (
    output i_cfg_we, i_cfg_addr, i_cfg_wdata, i_cpu_we, i_cpu_offset, i_cpu_wdata,
    input  o_cfg_rdata, o_fb_we, o_fb_offset, o_fb_wdata, o_irq
  );

  modport slave (
    input  i_cfg_we, i_cfg_addr, i_cfg_wdata, i_cpu_we, i_cpu_offset, i_cpu_wdata,
    output o_cfg_rdata, o_fb_we, o_fb_offset, o_fb_wdata, o_irq
  );
endinterface

// File: rtl/fb_fill_engine.sv
// Rectangle-fill engine in front of the framebuffer write port.
// It streams COLOR words over a clipped rectangle, one word per cycle.
// CPU stores share the output register and always win; when that happens the engine stalls for the cycle.
module fb_fill_engine #(
  parameter int ADDR_W = 18,
  parameter int STRIDE = 320,
  parameter int HEIGHT = 480
) (
  input  logic            CLK,
  input  logic            RST_X,
  fb_fill_engine_if.slave bus
);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] HEIGHT_A = ADDR_W'(HEIGHT);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  // programmed registers
  logic [8:0]  x0_q, y0_q, w_q, h_q;
  logic [31:0] color_q;
  logic        irq_en_q, done_q;
  // shadow copies used by the active fill
  logic [8:0]  sx0_q, sy0_q, sw_q, sh_q;
  logic [31:0] scolor_q;
  // walk state
  logic [ADDR_W-1:0] wc_q, hc_q, col_q, row_q, base_q;
  // output register
  logic              fb_we_q;
  logic [ADDR_W-1:0] fb_off_q;
  logic [31:0]       fb_data_q;

  logic ctrl_wr, start, abort, clr_done, busy;
  assign ctrl_wr  = bus.i_cfg_we && (bus.i_cfg_addr == 3'd5);
  // abort beats a start carried in the same write
  assign start    = ctrl_wr && bus.i_cfg_wdata[0] && !bus.i_cfg_wdata[2];
  assign abort    = ctrl_wr && bus.i_cfg_wdata[2];
  assign clr_done = ctrl_wr && bus.i_cfg_wdata[1];
  assign busy     = (state_q != S_IDLE);

  // Clipping terms; only meaningful when the origin lies on-screen, which the empty check guarantees.
  logic [ADDR_W-1:0] x0_e, y0_e, w_e, h_e, rem_w, rem_h, wclip, hclip;
  logic              empty, last_col, last_row, step;
  assign x0_e     = ADDR_W'(sx0_q);
  assign y0_e     = ADDR_W'(sy0_q);
  assign w_e      = ADDR_W'(sw_q);
  assign h_e      = ADDR_W'(sh_q);
  assign rem_w    = STRIDE_A - x0_e;
  assign rem_h    = HEIGHT_A - y0_e;
  assign wclip    = (w_e < rem_w) ? w_e : rem_w;
  assign hclip    = (h_e < rem_h) ? h_e : rem_h;
  assign empty    = (x0_e >= STRIDE_A) || (y0_e >= HEIGHT_A) || (w_e == '0) || (h_e == '0);
  assign last_col = (col_q == wc_q - ONE_A);
  assign last_row = (row_q == hc_q - ONE_A);
  // engine advances only when it owns the output port and the fill is not being aborted
  assign step     = (state_q == S_RUN) && !bus.i_cpu_we && !abort;

  // State register
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every non-idle transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: state_d = empty ? S_DONE : S_RUN;
      S_RUN:   if (step && last_col && last_row) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Programmed registers and sticky done flag (set beats clear)
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      x0_q <= '0; y0_q <= '0; w_q <= '0; h_q <= '0;
      color_q <= '0; irq_en_q <= 1'b0; done_q <= 1'b0;
    end else begin
      if (bus.i_cfg_we) begin
        case (bus.i_cfg_addr)
          3'd0: x0_q    <= bus.i_cfg_wdata[8:0];
          3'd1: y0_q    <= bus.i_cfg_wdata[8:0];
          3'd2: w_q     <= bus.i_cfg_wdata[8:0];
          3'd3: h_q     <= bus.i_cfg_wdata[8:0];
          3'd4: color_q <= bus.i_cfg_wdata;
          3'd5: irq_en_q <= bus.i_cfg_wdata[3];
          default: ;
        endcase
      end
      if (state_q == S_DONE && !abort) done_q <= 1'b1;
      else if (clr_done)               done_q <= 1'b0;
    end
  end

  // Shadow capture on start, setup of clipped extents, and the column/row walk
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      sx0_q <= '0; sy0_q <= '0; sw_q <= '0; sh_q <= '0; scolor_q <= '0;
      wc_q <= '0; hc_q <= '0; col_q <= '0; row_q <= '0; base_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        sx0_q <= x0_q; sy0_q <= y0_q; sw_q <= w_q; sh_q <= h_q; scolor_q <= color_q;
      end
      if (state_q == S_SETUP) begin
        wc_q   <= wclip;
        hc_q   <= hclip;
        base_q <= y0_e * STRIDE_A + x0_e;
        col_q  <= '0;
        row_q  <= '0;
      end else if (step) begin
        if (last_col) begin
          col_q  <= '0;
          base_q <= base_q + STRIDE_A;
          row_q  <= row_q + ONE_A;
        end else begin
          col_q  <= col_q + ONE_A;
        end
      end
    end
  end

  // Output register: CPU store first, otherwise the engine's current word
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      fb_we_q <= 1'b0; fb_off_q <= '0; fb_data_q <= '0;
    end else if (bus.i_cpu_we) begin
      fb_we_q <= 1'b1; fb_off_q <= bus.i_cpu_offset; fb_data_q <= bus.i_cpu_wdata;
    end else if (step) begin
      fb_we_q <= 1'b1; fb_off_q <= base_q + col_q; fb_data_q <= scolor_q;
    end else begin
      fb_we_q <= 1'b0;
    end
  end

  // Register read mux
  always_comb begin
    bus.o_cfg_rdata = '0;
    case (bus.i_cfg_addr)
      3'd0: bus.o_cfg_rdata = {23'd0, x0_q};
      3'd1: bus.o_cfg_rdata = {23'd0, y0_q};
      3'd2: bus.o_cfg_rdata = {23'd0, w_q};
      3'd3: bus.o_cfg_rdata = {23'd0, h_q};
      3'd4: bus.o_cfg_rdata = color_q;
      3'd5: bus.o_cfg_rdata = {28'd0, irq_en_q, 1'b0, done_q, busy};
      default: ;
    endcase
  end

  assign bus.o_fb_we     = fb_we_q;
  assign bus.o_fb_offset = fb_off_q;
  assign bus.o_fb_wdata  = fb_data_q;
  assign bus.o_irq       = done_q & irq_en_q;
endmodule

// File: tb/tb_fb_fill_engine.sv
// Directed bench for fb_fill_engine. Expected framebuffer writes go into a queue
// and a negedge monitor pops and compares every write the engine presents.
module tb_fb_fill_engine;
  localparam int ADDR_W = 18;

  logic CLK, RST_X;
  fb_fill_engine_if #(.ADDR_W(ADDR_W)) bus();

  fb_fill_engine #(.ADDR_W(ADDR_W), .STRIDE(320), .HEIGHT(480)) dut (
    .CLK(CLK), .RST_X(RST_X), .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] off; logic [31:0] data; } exp_t;
  exp_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int off, input logic [31:0] data);
    exp_t e;
    e.off = off; e.data = data;
    sbq.push_back(e);
  endtask

  // Monitor: every presented write must match the head of the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_X && bus.o_fb_we) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write: got offset %0d data 0x%08h expected no write", bus.o_fb_offset, bus.o_fb_wdata);
        end else begin
          e = sbq.pop_front();
          chk("fb_offset", 32'(bus.o_fb_offset), e.off);
          chk("fb_wdata", bus.o_fb_wdata, e.data);
        end
      end
    end
  end

  // Drive one register write; returns 1 ns after the capturing edge
  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    bus.i_cfg_we = 1'b1; bus.i_cfg_addr = a; bus.i_cfg_wdata = d;
    @(posedge CLK); #1;
    bus.i_cfg_we = 1'b0; bus.i_cfg_addr = 3'd5;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.i_cfg_addr = a;
    #1 d = bus.o_cfg_rdata;
  endtask

  task automatic program_rect(input int x0, input int y0, input int w, input int h, input logic [31:0] c);
    cfg_write(3'd0, 32'(x0)); cfg_write(3'd1, 32'(y0));
    cfg_write(3'd2, 32'(w));  cfg_write(3'd3, 32'(h));
    cfg_write(3'd4, c);
  endtask

  // Bounded wait for busy to drop; an expired bound counts as a failure
  task automatic wait_idle(input string name);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 200; i++) begin
      rd(3'd5, v);
      if (!v[0]) break;
      @(posedge CLK); #1;
    end
    if (v[0]) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got busy=1 expected busy=0 within 200 cycles", name);
    end
  endtask

  initial begin
    logic [31:0] v;
    RST_X = 1'b0;
    bus.i_cfg_we = 1'b0; bus.i_cfg_addr = 3'd5; bus.i_cfg_wdata = '0;
    bus.i_cpu_we = 1'b0; bus.i_cpu_offset = '0; bus.i_cpu_wdata = '0;
    #1;
    chk("reset_fb_we", 32'(bus.o_fb_we), 32'd0);
    chk("reset_irq", 32'(bus.o_irq), 32'd0);
    rd(3'd5, v); chk("reset_ctrl", v, 32'd0);
    repeat (2) @(posedge CLK);
    #2 RST_X = 1'b1;
    @(posedge CLK); #1;

    // 1: basic 4x2 fill at (2,3)
    program_rect(2, 3, 4, 2, 32'hF800F800);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) push(962 + r*320 + c, 32'hF800F800);
    cfg_write(3'd5, 32'h1);
    rd(3'd5, v); chk("t1_busy_after_start", v & 32'h1, 32'h1);
    @(posedge CLK); #1 chk("t1_no_write_edge1", 32'(bus.o_fb_we), 32'd0);
    @(posedge CLK); #1 chk("t1_first_write_edge2", 32'(bus.o_fb_we), 32'd1);
    chk("t1_first_offset", 32'(bus.o_fb_offset), 32'd962);
    // config write and a second start while busy: registers change, fill does not
    cfg_write(3'd0, 32'd100);
    cfg_write(3'd5, 32'h1);
    wait_idle("t1");
    rd(3'd5, v); chk("t1_done", v, 32'h2);
    rd(3'd0, v); chk("t1_x0_updated", v, 32'd100);
    chk("t1_all_writes_seen", 32'(sbq.size()), 32'd0);

    // 2: empty rectangles (W=0, then H=0)
    for (int k = 0; k < 2; k++) begin
      cfg_write(3'd5, 32'h2);
      rd(3'd5, v); chk("t2_done_cleared", v, 32'h0);
      program_rect(5, 5, (k == 0) ? 0 : 3, (k == 0) ? 2 : 0, 32'h12345678);
      cfg_write(3'd5, 32'h1);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      rd(3'd5, v); chk("t2_busy_dropped", v & 32'h1, 32'h0);
      @(posedge CLK); #1;
      rd(3'd5, v); chk("t2_done_edge3", v, 32'h2);
    end

    // 3: clipped at the bottom-right corner
    program_rect(318, 479, 10, 5, 32'h07E007E0);
    push(153598, 32'h07E007E0);
    push(153599, 32'h07E007E0);
    cfg_write(3'd5, 32'h1);
    wait_idle("t3");
    rd(3'd5, v); chk("t3_done", v, 32'h2);
    chk("t3_all_writes_seen", 32'(sbq.size()), 32'd0);

    // 4: CPU store on the second engine cycle
    program_rect(0, 0, 4, 1, 32'h001F001F);
    push(0, 32'h001F001F);
    push(7, 32'h00001234);
    push(1, 32'h001F001F);
    push(2, 32'h001F001F);
    push(3, 32'h001F001F);
    cfg_write(3'd5, 32'h1);
    @(posedge CLK);
    @(posedge CLK); #1;
    bus.i_cpu_we = 1'b1; bus.i_cpu_offset = 18'd7; bus.i_cpu_wdata = 32'h00001234;
    @(posedge CLK); #1;
    bus.i_cpu_we = 1'b0;
    wait_idle("t4");
    chk("t4_all_writes_seen", 32'(sbq.size()), 32'd0);

    // 5: abort after 3 of 16 writes, then a normal fill with interrupt
    cfg_write(3'd5, 32'h2);
    program_rect(0, 10, 16, 1, 32'hAAAA5555);
    push(3200, 32'hAAAA5555);
    push(3201, 32'hAAAA5555);
    push(3202, 32'hAAAA5555);
    cfg_write(3'd5, 32'h1);
    repeat (4) @(posedge CLK);
    #1 cfg_write(3'd5, 32'h4);
    rd(3'd5, v); chk("t5_after_abort", v, 32'h0);
    repeat (4) @(posedge CLK);
    #1 chk("t5_abort_writes", 32'(sbq.size()), 32'd0);
    program_rect(0, 10, 2, 1, 32'h0000FFFF);
    push(3200, 32'h0000FFFF);
    push(3201, 32'h0000FFFF);
    cfg_write(3'd5, 32'h9);
    wait_idle("t5");
    chk("t5_irq_set", 32'(bus.o_irq), 32'd1);
    cfg_write(3'd5, 32'hA);
    chk("t5_irq_cleared", 32'(bus.o_irq), 32'd0);
    rd(3'd5, v); chk("t5_ctrl_irq_en_only", v, 32'h8);

    // 6: reset in the middle of a fill
    program_rect(0, 0, 16, 1, 32'hCAFEBABE);
    push(0, 32'hCAFEBABE);
    push(1, 32'hCAFEBABE);
    cfg_write(3'd5, 32'h1);
    repeat (3) @(posedge CLK);
    #6 RST_X = 1'b0;
    #1 chk("t6_async_fb_we", 32'(bus.o_fb_we), 32'd0);
    repeat (2) @(posedge CLK);
    #2 RST_X = 1'b1;
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), v); chk("t6_reg_zero", v, 32'd0);
    end
    repeat (5) @(posedge CLK);
    #1 chk("t6_writes_seen", 32'(sbq.size()), 32'd0);
    chk("t6_irq", 32'(bus.o_irq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end
endmodule
